i2c_eeprom_arb: RTL and testbench
=================================

Name: i2c_eeprom_arb

Overview:
- Sequencer and arbiter in front of the I2C EEPROM byte engine.
- Two client ports each post single-byte read or write commands. The block arbitrates between them round-robin and launches one engine transaction at a time with a one-cycle start pulse.
- Holds the command fields stable until the engine's end pulse, then returns read data and a done pulse to the client that won arbitration.
- Clocked by the engine's divided I2C state clock, so start and end pulses line up one-to-one with the engine's state machine.

Parameters:
- WR_WAIT_CYC, 5000: post-write idle cycles covering the EEPROM internal write time (5 ms at 1 MHz).
- WAIT_CNT_W, 13: width of the write-wait counter; must satisfy 2^WAIT_CNT_W > WR_WAIT_CYC.
- INIT_PRIO, 0: client that holds priority after reset.

Ports:
- sys_clk in 1: single clock; connected to the engine's i2c_clk.
- sys_rst in 1: asynchronous, active-high reset.
- req0 in 1: client 0 command request, level.
- rw0 in 1: client 0 direction; 1 = read, 0 = write.
- addr0 in 16: client 0 byte address.
- wdata0 in 8: client 0 write data.
- ack0 out 1: client 0 command accepted, one-cycle pulse.
- done0 out 1: client 0 transaction finished, one-cycle pulse.
- req1, rw1, addr1, wdata1, ack1, done1: same as client 0, for client 1.
- rd_data out 8: read result; valid in the done cycle.
- busy out 1: high from accept until return to IDLE.
- i2c_start out 1: engine start, one-cycle pulse.
- wr_en out 1: engine write enable.
- rd_en out 1: engine read enable.
- byte_addr out 16: engine address.
- wr_data out 8: engine write data.
- i2c_end in 1: engine completion pulse.
- i2c_rd_data in 8: engine read data.

Behaviour:
- Reset: every output is 0; state = IDLE; prio = INIT_PRIO; wait counter = 0. Reset mid-transaction aborts silently: no done pulse is issued, and the engine is reset by its own reset.
- States: IDLE, START, BUSY, WR_WAIT.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one reqN high: client N wins.
  - Both high: client `prio` wins.
  - On a win, latch rwN, addrN and wdataN, then go to START.
- START (one cycle):
  - ackN = 1 for the winner; i2c_start = 1; busy = 1.
  - Drive byte_addr and wr_data from the latch. wr_en = ~rw and rd_en = rw, exactly one of them high.
  - Next state: BUSY.
- BUSY:
  - wr_en, rd_en, byte_addr and wr_data are held constant; i2c_start = 0.
  - On i2c_end = 1: doneN = 1 for one cycle; rd_data <= i2c_rd_data if the command was a read, otherwise unchanged; prio <= the other client; wr_en = rd_en = 0 from the next cycle.
  - Next state: WR_WAIT for a write (when the feature is enabled), else IDLE.
- WR_WAIT:
  - The counter counts 0 .. WR_WAIT_CYC-1, then the block returns to IDLE and clears the counter.
  - busy stays 1 throughout.
- Latency:
  - A request sampled in IDLE at cycle t gives ack and i2c_start at t+1.
  - done is seen in the same cycle the block samples i2c_end = 1.
- Handshake rules:
  - A client holds reqN and its command stable until ackN, and may drop reqN after ackN.
  - A request held through ack with no new command is not re-served unless reqN is still high when the block returns to IDLE; clients must drop req within one cycle of ack.
  - Requests arriving during START, BUSY or WR_WAIT are not sampled; they wait.
  - A req dropped before ack leaves no side effects.
- Arbitration is fair: under continuous dual requests the block alternates 0, 1, 0, 1, …
- An i2c_end seen outside BUSY is ignored.

Optional Feature:
- Macro: I2C_ARB_WR_WAIT_EN.
- Defined: WR_WAIT is present as described, so EEPROM write-cycle time is enforced before the next transaction.
- Undefined: the WR_WAIT state and counter are removed, and BUSY goes directly to IDLE after every transaction. WR_WAIT_CYC and WAIT_CNT_W are then unused.

Decomposition:
- Package i2c_arb_pkg: state encoding constants (IDLE=0, START=1, BUSY=2, WR_WAIT=3); RW_READ = 1 / RW_WRITE = 0; a command record {rw, addr[15:0], wdata[7:0]} with its width constant (25).
- One natural sub-module: i2c_rr_arb2. It is a combinational 2-way round-robin picker with inputs req[1:0] and prio, and outputs gnt[1:0] (one-hot or zero).

Test Plan:
- Single write: req0 with rw0 = 0, addr0 = 16'h0012, wdata0 = 8'hA5. Expect ack0 and i2c_start 1 cycle later; wr_en = 1, byte_addr = 0012, wr_data = A5 held until i2c_end; done0 in the i2c_end cycle; busy stays high for WR_WAIT_CYC more cycles.
- Single read: req1 with rw1 = 1, addr1 = 16'h0034; the engine model returns 8'h5A with i2c_end. Expect rd_en = 1, done1 = 1, rd_data = 5A in the same cycle.
- Contention: req0 and req1 rise together after reset with INIT_PRIO = 0. Expect ack0 first, then ack1 after the first transaction; with requests held continuously, grants alternate 0, 1, 0, 1.
- Late request: req0 asserted while BUSY. Expect no ack0 until IDLE is re-entered; engine fields are unchanged during BUSY.
- Reset mid-BUSY: pulse sys_rst while waiting for i2c_end. Expect all outputs 0 immediately, no done pulse, prio = INIT_PRIO, and a normal transaction afterwards.
- Build with I2C_ARB_WR_WAIT_EN undefined: back-to-back writes give the second i2c_start 2 cycles after the first done.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C EEPROM command arbiter: state encoding,
// direction codes and the latched command record.
package i2c_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      BUSY    = 2'd2,
      WR_WAIT = 2'd3
   } arb_state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam int CMD_W = 25;

   typedef struct packed {
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } arb_cmd_t;

endpackage

// File: rtl/i2c_rr_arb2.sv
// Two-way round-robin picker. When both clients request, prio selects
// the winner; a single requester always wins. Grant is one-hot or zero.
module i2c_rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt
);

   // pick the winner from the request pair and the current priority holder
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = prio ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/i2c_eeprom_arb.sv
// Sequencer/arbiter in front of the I2C EEPROM byte engine. Two clients
// post single-byte commands; one engine transaction runs at a time.
// Optional feature macro: I2C_ARB_WR_WAIT_EN adds a post-write idle
// period (WR_WAIT) covering the EEPROM internal write-cycle time.
//
// state   | meaning
// IDLE    | waiting for a client request; arbitration happens here
// START   | ack to the winner and engine start pulse
// BUSY    | engine running, command fields held until i2c_end
// WR_WAIT | post-write idle count (only with I2C_ARB_WR_WAIT_EN)
module i2c_eeprom_arb
   import i2c_arb_pkg::*;
#(
   parameter int   WR_WAIT_CYC = 5000,
   parameter int   WAIT_CNT_W  = 13,
   parameter logic INIT_PRIO   = 1'b0
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        req0,
   input  logic        rw0,
   input  logic [15:0] addr0,
   input  logic [7:0]  wdata0,
   output logic        ack0,
   output logic        done0,
   input  logic        req1,
   input  logic        rw1,
   input  logic [15:0] addr1,
   input  logic [7:0]  wdata1,
   output logic        ack1,
   output logic        done1,
   output logic [7:0]  rd_data,
   output logic        busy,
   output logic        i2c_start,
   output logic        wr_en,
   output logic        rd_en,
   output logic [15:0] byte_addr,
   output logic [7:0]  wr_data,
   input  logic        i2c_end,
   input  logic [7:0]  i2c_rd_data
);

   arb_state_t       state;
   arb_cmd_t         cmd_q;
   arb_cmd_t         win_cmd;
   logic             owner_q;
   logic             prio_q;
   logic [1:0]       gnt;
   logic [7:0]       rd_data_q;
   logic             end_hit;
   logic [CMD_W-1:0] cmd0;
   logic [CMD_W-1:0] cmd1;

`ifdef I2C_ARB_WR_WAIT_EN
   logic [WAIT_CNT_W-1:0] wait_cnt;
`else
   logic unused_wait_cfg;
   assign unused_wait_cfg = (WR_WAIT_CYC > 0) ^ (WAIT_CNT_W > 0);
`endif

   i2c_rr_arb2 u_rr (
      .req  ({req1, req0}),
      .prio (prio_q),
      .gnt  (gnt)
   );

   assign cmd0    = {rw0, addr0, wdata0};
   assign cmd1    = {rw1, addr1, wdata1};
   assign win_cmd = gnt[1] ? arb_cmd_t'(cmd1) : arb_cmd_t'(cmd0);

   // done and read data are decoded from i2c_end so the client sees them
   // in the very cycle the engine reports completion
   assign end_hit = (state == BUSY) && i2c_end;
   assign done0   = end_hit && !owner_q;
   assign done1   = end_hit && owner_q;
   assign rd_data = (end_hit && (cmd_q.rw == RW_READ)) ? i2c_rd_data : rd_data_q;

   // arbitration, command latch and engine handshake sequencing
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         cmd_q     <= '0;
         owner_q   <= 1'b0;
         prio_q    <= INIT_PRIO;
         rd_data_q <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         busy      <= 1'b0;
         i2c_start <= 1'b0;
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         byte_addr <= '0;
         wr_data   <= '0;
`ifdef I2C_ARB_WR_WAIT_EN
         wait_cnt  <= '0;
`endif
      end else begin
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         i2c_start <= 1'b0;
         case (state)
            IDLE: begin
               if (|gnt) begin
                  cmd_q     <= win_cmd;
                  owner_q   <= gnt[1];
                  ack0      <= gnt[0];
                  ack1      <= gnt[1];
                  i2c_start <= 1'b1;
                  busy      <= 1'b1;
                  wr_en     <= (win_cmd.rw == RW_WRITE);
                  rd_en     <= (win_cmd.rw == RW_READ);
                  byte_addr <= win_cmd.addr;
                  wr_data   <= win_cmd.wdata;
                  state     <= START;
               end
            end
            START: begin
               state <= BUSY;
            end
            BUSY: begin
               if (i2c_end) begin
                  if (cmd_q.rw == RW_READ) begin
                     rd_data_q <= i2c_rd_data;
                  end
                  prio_q <= ~owner_q;
                  wr_en  <= 1'b0;
                  rd_en  <= 1'b0;
`ifdef I2C_ARB_WR_WAIT_EN
                  if (cmd_q.rw == RW_WRITE) begin
                     state <= WR_WAIT;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
`else
                  state <= IDLE;
                  busy  <= 1'b0;
`endif
               end
            end
            WR_WAIT: begin
`ifdef I2C_ARB_WR_WAIT_EN
               if (wait_cnt == WAIT_CNT_W'(WR_WAIT_CYC - 1)) begin
                  wait_cnt <= '0;
                  state    <= IDLE;
                  busy     <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`else
               state <= IDLE;
               busy  <= 1'b0;
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_eeprom_arb.sv
// Self-checking bench for i2c_eeprom_arb: transaction-level reference
// model compared every cycle, directed scenarios with literal checks,
// then randomized clients and engine. Follows the I2C_ARB_WR_WAIT_EN build.
module tb_i2c_eeprom_arb;

   localparam int   TB_WAIT   = 12;
   localparam int   TB_CNT_W  = 4;
   localparam logic TB_PRIO   = 1'b0;
`ifdef I2C_ARB_WR_WAIT_EN
   localparam int   EFF_WAIT  = TB_WAIT;
`else
   localparam int   EFF_WAIT  = 0;
`endif

   logic        sys_clk, sys_rst;
   logic        req0, rw0, ack0, done0;
   logic [15:0] addr0;
   logic [7:0]  wdata0;
   logic        req1, rw1, ack1, done1;
   logic [15:0] addr1;
   logic [7:0]  wdata1;
   logic [7:0]  rd_data;
   logic        busy, i2c_start, wr_en, rd_en;
   logic [15:0] byte_addr;
   logic [7:0]  wr_data;
   logic        i2c_end;
   logic [7:0]  i2c_rd_data;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // engine behaviour knobs
   bit       eng_rand = 0, eng_spur = 0, eng_force = 0, eng_pend = 0;
   int       eng_lat = 3, eng_cnt = 0;
   logic [7:0] eng_force_val = 8'h00;

   i2c_eeprom_arb #(
      .WR_WAIT_CYC (TB_WAIT),
      .WAIT_CNT_W  (TB_CNT_W),
      .INIT_PRIO   (TB_PRIO)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .req0        (req0),
      .rw0         (rw0),
      .addr0       (addr0),
      .wdata0      (wdata0),
      .ack0        (ack0),
      .done0       (done0),
      .req1        (req1),
      .rw1         (rw1),
      .addr1       (addr1),
      .wdata1      (wdata1),
      .ack1        (ack1),
      .done1       (done1),
      .rd_data     (rd_data),
      .busy        (busy),
      .i2c_start   (i2c_start),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .byte_addr   (byte_addr),
      .wr_data     (wr_data),
      .i2c_end     (i2c_end),
      .i2c_rd_data (i2c_rd_data)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int wait_len(input bit rw);
      return rw ? 0 : EFF_WAIT;
   endfunction

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // ---------------- engine model ----------------
   initial begin
      i2c_end = 1'b0;
      i2c_rd_data = 8'h00;
      forever begin
         tick();
         i2c_end = 1'b0;
         i2c_rd_data = 8'($urandom);
         if (sys_rst) begin
            eng_pend = 0;
         end else if (eng_pend) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               i2c_end = 1'b1;
               eng_pend = 0;
               if (eng_force) i2c_rd_data = eng_force_val;
            end
         end else if (i2c_start) begin
            eng_pend = 1;
            eng_cnt = eng_rand ? int'($urandom_range(1, 6)) : eng_lat;
         end else if (eng_spur && $urandom_range(0, 15) == 0) begin
            i2c_end = 1'b1;
         end
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   bit         m_act = 0, m_client = 0, m_rw = 0, m_prio = TB_PRIO;
   int         m_acc = -10, m_end = -1;
   logic [15:0] m_addr_o = '0;
   logic [7:0]  m_wd_o = '0, m_rd = '0;

   initial begin
      bit in_start, in_eng, e_done;
      bit win, any;
      logic [7:0] e_rdd;
      forever begin
         @(negedge sys_clk);
         cyc++;
         if (sys_rst) begin
            m_act = 0; m_end = -1; m_prio = TB_PRIO; m_rd = '0;
            m_addr_o = '0; m_wd_o = '0; m_client = 0; m_rw = 0;
         end else if (m_act && m_end >= 0 && cyc >= m_end + 1 + wait_len(m_rw)) begin
            m_act = 0;
         end
         in_start = !sys_rst && m_act && (cyc == m_acc + 1);
         in_eng   = !sys_rst && m_act && (cyc >= m_acc + 2) && (m_end < 0);
         e_done   = in_eng && (i2c_end === 1'b1);
         e_rdd    = (e_done && m_rw) ? i2c_rd_data : m_rd;
         chk("ack0", ack0, in_start && !m_client);
         chk("ack1", ack1, in_start && m_client);
         chk("i2c_start", i2c_start, in_start);
         chk("done0", done0, e_done && !m_client);
         chk("done1", done1, e_done && m_client);
         chk("busy", busy, !sys_rst && m_act);
         chk("wr_en", wr_en, (in_start || in_eng) && !m_rw);
         chk("rd_en", rd_en, (in_start || in_eng) && m_rw);
         chk("byte_addr", byte_addr, m_addr_o);
         chk("wr_data", wr_data, m_wd_o);
         chk("rd_data", rd_data, e_rdd);
         if (!sys_rst) begin
            if (e_done) begin
               m_end = cyc;
               if (m_rw) m_rd = i2c_rd_data;
               m_prio = !m_client;
            end
            if (!m_act) begin
               any = req0 || req1;
               win = (req0 && req1) ? m_prio : req1;
               if (any) begin
                  m_act = 1; m_acc = cyc; m_end = -1; m_client = win;
                  m_rw     = win ? rw1 : rw0;
                  m_addr_o = win ? addr1 : addr0;
                  m_wd_o   = win ? wdata1 : wdata0;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_done(input bit k, output int n, output int acks);
      bit got = 0;
      n = 0; acks = 0;
      while (!got && n < 40) begin
         tick();
         @(negedge sys_clk);
         n++;
         if (k ? done1 : done0) got = 1;
         else if (ack0 || ack1) acks++;
      end
      chk(k ? "done1 seen" : "done0 seen", got, 1);
   endtask

   task automatic count_busy(output int cnt);
      bit idle = 0;
      cnt = 0;
      while (!idle && cnt < 200) begin
         tick();
         @(negedge sys_clk);
         if (!busy) idle = 1;
         else cnt++;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         tick();
         @(negedge sys_clk);
         n++;
      end
      chk("return to idle", busy, 0);
   endtask

   task automatic rand_client(input logic ack, inout logic req, inout logic rw,
                              inout logic [15:0] addr, inout logic [7:0] wd);
      if (req) begin
         if (ack) begin
            if ($urandom_range(0, 2) == 0) begin
               rw = 1'($urandom); addr = 16'($urandom); wd = 8'($urandom);
            end else begin
               req = 1'b0;
            end
         end else if ($urandom_range(0, 29) == 0) begin
            req = 1'b0;
         end
      end else if ($urandom_range(0, 3) == 0) begin
         req = 1'b1;
         rw = 1'($urandom); addr = 16'($urandom); wd = 8'($urandom);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n, acks, cnt, k, ng;
      int order [4];
      sys_rst = 1'b1;
      req0 = 0; rw0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; rw1 = 0; addr1 = '0; wdata1 = '0;
      repeat (2) tick();
      @(negedge sys_clk);
      chk("reset busy", busy, 0);
      chk("reset i2c_start", i2c_start, 0);
      chk("reset rd_data", rd_data, 0);
      chk("reset byte_addr", byte_addr, 0);
      tick();
      sys_rst = 1'b0;
      tick(); tick();

      // single write from client 0
      req0 = 1; rw0 = 0; addr0 = 16'h0012; wdata0 = 8'hA5;
      tick();
      req0 = 0;
      @(negedge sys_clk);
      chk("wr ack0", ack0, 1);
      chk("wr i2c_start", i2c_start, 1);
      chk("wr wr_en", wr_en, 1);
      chk("wr rd_en", rd_en, 0);
      chk("wr byte_addr", byte_addr, 16'h0012);
      chk("wr wr_data", wr_data, 8'hA5);
      wait_done(0, n, acks);
      chk("wr done latency", n, 3);
      chk("wr wr_en at done", wr_en, 1);
      chk("wr byte_addr at done", byte_addr, 16'h0012);
      count_busy(cnt);
      chk("wr busy tail", cnt, EFF_WAIT);

      // single read from client 1
      tick();
      req1 = 1; rw1 = 1; addr1 = 16'h0034; wdata1 = 8'h77;
      eng_force = 1; eng_force_val = 8'h5A;
      tick();
      req1 = 0;
      @(negedge sys_clk);
      chk("rd ack1", ack1, 1);
      chk("rd ack0", ack0, 0);
      chk("rd rd_en", rd_en, 1);
      chk("rd byte_addr", byte_addr, 16'h0034);
      wait_done(1, n, acks);
      chk("rd rd_data at done", rd_data, 8'h5A);
      chk("rd rd_en at done", rd_en, 1);
      tick();
      @(negedge sys_clk);
      eng_force = 0;
      chk("rd rd_data held", rd_data, 8'h5A);
      chk("rd rd_en cleared", rd_en, 0);
      chk("rd busy cleared", busy, 0);

      // late request while busy
      tick();
      req1 = 1; rw1 = 1; addr1 = 16'h4321;
      tick();
      req1 = 0;
      tick();
      req0 = 1; rw0 = 0; addr0 = 16'h0BEE; wdata0 = 8'h3C;
      eng_lat = 4;
      wait_done(1, n, acks);
      chk("late no early ack", acks, 0);
      k = 0;
      do begin
         tick();
         @(negedge sys_clk);
         k++;
      end while (!ack0 && k < 50);
      chk("late ack delay", k, 2);
      chk("late byte_addr", byte_addr, 16'h0BEE);
      tick();
      req0 = 0;
      wait_idle();

      // reset mid-BUSY (prio currently with client 1)
      tick();
      req1 = 1; rw1 = 0; addr1 = 16'h0055; wdata1 = 8'h11;
      eng_lat = 10;
      tick();
      req1 = 0;
      tick(); tick();
      sys_rst = 1'b1;
      @(negedge sys_clk);
      chk("rst busy", busy, 0);
      chk("rst wr_en", wr_en, 0);
      chk("rst byte_addr", byte_addr, 0);
      chk("rst done1", done1, 0);
      tick(); tick();
      sys_rst = 1'b0;
      eng_lat = 3;

      // contention with continuous requests: grants must alternate from 0
      tick();
      req0 = 1; rw0 = 1'($urandom); addr0 = 16'($urandom); wdata0 = 8'($urandom);
      req1 = 1; rw1 = 1'($urandom); addr1 = 16'($urandom); wdata1 = 8'($urandom);
      ng = 0; n = 0;
      while (ng < 4 && n < 400) begin
         tick();
         n++;
         if (ack0) begin
            order[ng] = 0; ng++;
            rw0 = 1'($urandom); addr0 = 16'($urandom); wdata0 = 8'($urandom);
         end
         if (ack1 && ng < 4) begin
            order[ng] = 1; ng++;
            rw1 = 1'($urandom); addr1 = 16'($urandom); wdata1 = 8'($urandom);
         end
      end
      req0 = 0; req1 = 0;
      chk("contention grant count", ng, 4);
      for (int i = 0; i < ng; i++) chk("contention grant order", order[i], i % 2);
      @(negedge sys_clk);
      wait_idle();

      // back-to-back writes from one client
      tick();
      req0 = 1; rw0 = 0; addr0 = 16'h0100; wdata0 = 8'h01;
      tick();
      addr0 = 16'h0101; wdata0 = 8'h02;
      wait_done(0, n, acks);
      k = 0;
      do begin
         tick();
         @(negedge sys_clk);
         k++;
      end while (!i2c_start && k < 100);
      chk("b2b start gap", k, EFF_WAIT + 2);
      chk("b2b byte_addr", byte_addr, 16'h0101);
      tick();
      req0 = 0;
      wait_idle();

      // randomized traffic with a reset pulse in the middle
      eng_rand = 1; eng_spur = 1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (i == 1500) sys_rst = 1'b1;
         if (i == 1503) sys_rst = 1'b0;
         rand_client(ack0, req0, rw0, addr0, wdata0);
         rand_client(ack1, req1, rw1, addr1, wdata1);
      end
      tick();
      req0 = 0; req1 = 0; eng_spur = 0;
      @(negedge sys_clk);
      wait_idle();
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
